// File: rtl/ebpc_pkg.sv
// ============================================================================
// Module : ebpc_pkg
// Shared types and constants for the EBPC decoder arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ebpc_pkg;

  localparam int LOG_MAX_WORDS = 8;
  localparam int MAX_REQ       = 8;
  localparam int PTR_W         = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Round-robin successor of requester idx among n requesters.
  function automatic logic [PTR_W-1:0] rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? '0 : PTR_W'(idx + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ebpc_decoder_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import ebpc_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_vld
);

  always_comb begin
    o_gnt = '0;
    o_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!o_vld && i_req[i] && (i == (int'(i_ptr) + k) % N_REQ)) begin
          o_gnt[i] = 1'b1;
          o_vld    = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ebpc_decoder_arbiter.sv
// ============================================================================
// Module : ebpc_decoder_arbiter
// Shares one ebpc_decoder among N_REQ requesters, one whole block per grant.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ebpc_decoder_arbiter
  import ebpc_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8,
  parameter int NW_W   = LOG_MAX_WORDS
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ*NW_W-1:0]   req_nw_i,
  input  logic [N_REQ-1:0]        req_nw_vld_i,
  output logic [N_REQ-1:0]        req_nw_rdy_o,
  input  logic [N_REQ*DATA_W-1:0] req_bpc_i,
  input  logic [N_REQ-1:0]        req_bpc_vld_i,
  output logic [N_REQ-1:0]        req_bpc_rdy_o,
  input  logic [N_REQ*DATA_W-1:0] req_znz_i,
  input  logic [N_REQ-1:0]        req_znz_vld_i,
  output logic [N_REQ-1:0]        req_znz_rdy_o,
  output logic [DATA_W-1:0]       req_data_o,
  output logic [N_REQ-1:0]        req_data_vld_o,
  input  logic [N_REQ-1:0]        req_data_rdy_i,
  output logic                    req_data_last_o,
  output logic [NW_W-1:0]         dec_nw_o,
  output logic                    dec_nw_vld_o,
  input  logic                    dec_nw_rdy_i,
  output logic [DATA_W-1:0]       dec_bpc_o,
  output logic                    dec_bpc_vld_o,
  input  logic                    dec_bpc_rdy_i,
  output logic [DATA_W-1:0]       dec_znz_o,
  output logic                    dec_znz_vld_o,
  input  logic                    dec_znz_rdy_i,
  input  logic [DATA_W-1:0]       dec_data_i,
  input  logic                    dec_vld_i,
  output logic                    dec_rdy_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    busy_o
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [N_REQ-1:0]  r_grant;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [NW_W-1:0]   r_remaining;
  logic [N_REQ-1:0]  w_arb_gnt;
  logic              w_arb_vld;
  logic [PTR_W-1:0]  w_ptr_after;
  logic              w_hs_nw;
  logic              w_hs_data;
  logic              w_last_word;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .i_req (req_nw_vld_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_vld (w_arb_vld)
  );

  assign w_hs_nw     = dec_nw_vld_o & dec_nw_rdy_i;
  assign w_hs_data   = dec_vld_i & dec_rdy_o;
  assign w_last_word = (r_remaining == NW_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_arb_vld) w_state_nxt = HDR;
      HDR:     if (w_hs_nw) w_state_nxt = (dec_nw_o != '0) ? DATA : IDLE;
      DATA:    if (w_hs_data && w_last_word) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pointer moves past the owner whenever its grant is released.
  always_comb begin
    w_ptr_after = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) w_ptr_after = rr_next(i, N_REQ);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_arb_vld) r_grant <= w_arb_gnt;
        HDR: begin
          if (w_hs_nw) begin
            r_remaining <= dec_nw_o;
            if (dec_nw_o == '0) begin
              r_grant  <= '0;
              r_rr_ptr <= w_ptr_after;
            end
          end
        end
        DATA: begin
          if (w_hs_data) begin
            r_remaining <= r_remaining - NW_W'(1);
            if (w_last_word) begin
              r_grant  <= '0;
              r_rr_ptr <= w_ptr_after;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Every requester-facing rdy/vld goes only through the owner's mux leg.
  always_comb begin
    dec_nw_o        = '0;
    dec_nw_vld_o    = 1'b0;
    req_nw_rdy_o    = '0;
    dec_bpc_o       = '0;
    dec_bpc_vld_o   = 1'b0;
    req_bpc_rdy_o   = '0;
    dec_znz_o       = '0;
    dec_znz_vld_o   = 1'b0;
    req_znz_rdy_o   = '0;
    req_data_o      = '0;
    req_data_vld_o  = '0;
    req_data_last_o = 1'b0;
    dec_rdy_o       = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        if (r_state == HDR) begin
          dec_nw_o        = req_nw_i[i*NW_W +: NW_W];
          dec_nw_vld_o    = req_nw_vld_i[i];
          req_nw_rdy_o[i] = dec_nw_rdy_i;
        end
        if (r_state == HDR || r_state == DATA) begin
          dec_bpc_o        = req_bpc_i[i*DATA_W +: DATA_W];
          dec_bpc_vld_o    = req_bpc_vld_i[i];
          req_bpc_rdy_o[i] = dec_bpc_rdy_i;
          dec_znz_o        = req_znz_i[i*DATA_W +: DATA_W];
          dec_znz_vld_o    = req_znz_vld_i[i];
          req_znz_rdy_o[i] = dec_znz_rdy_i;
        end
        if (r_state == DATA) begin
          req_data_o        = dec_data_i;
          req_data_vld_o[i] = dec_vld_i;
          dec_rdy_o         = req_data_rdy_i[i];
          req_data_last_o   = w_last_word & dec_vld_i;
        end
      end
    end
  end

  assign grant_o = r_grant;
  assign busy_o  = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ebpc_decoder_arbiter.sv
// ============================================================================
// Module : tb_ebpc_decoder_arbiter
// Directed/random bench for ebpc_decoder_arbiter with a round-robin model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ebpc_decoder_arbiter;
  import ebpc_pkg::*;

  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int NWW = LOG_MAX_WORDS;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N*NWW-1:0] req_nw_i;
  logic [N-1:0]    req_nw_vld_i, req_nw_rdy_o;
  logic [N*DW-1:0] req_bpc_i, req_znz_i;
  logic [N-1:0]    req_bpc_vld_i, req_bpc_rdy_o, req_znz_vld_i, req_znz_rdy_o;
  logic [DW-1:0]   req_data_o;
  logic [N-1:0]    req_data_vld_o, req_data_rdy_i;
  logic            req_data_last_o;
  logic [NWW-1:0]  dec_nw_o;
  logic            dec_nw_vld_o, dec_nw_rdy_i;
  logic [DW-1:0]   dec_bpc_o, dec_znz_o, dec_data_i;
  logic            dec_bpc_vld_o, dec_bpc_rdy_i, dec_znz_vld_o, dec_znz_rdy_i;
  logic            dec_vld_i, dec_rdy_o;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  int n_assert = 0;
  int n_fail   = 0;
  int nwq [N][$];
  int m_ptr = 0;

  always #5 clk = ~clk;

  ebpc_decoder_arbiter #(.N_REQ(N), .DATA_W(DW), .NW_W(NWW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_nw_i(req_nw_i), .req_nw_vld_i(req_nw_vld_i), .req_nw_rdy_o(req_nw_rdy_o),
    .req_bpc_i(req_bpc_i), .req_bpc_vld_i(req_bpc_vld_i), .req_bpc_rdy_o(req_bpc_rdy_o),
    .req_znz_i(req_znz_i), .req_znz_vld_i(req_znz_vld_i), .req_znz_rdy_o(req_znz_rdy_o),
    .req_data_o(req_data_o), .req_data_vld_o(req_data_vld_o),
    .req_data_rdy_i(req_data_rdy_i), .req_data_last_o(req_data_last_o),
    .dec_nw_o(dec_nw_o), .dec_nw_vld_o(dec_nw_vld_o), .dec_nw_rdy_i(dec_nw_rdy_i),
    .dec_bpc_o(dec_bpc_o), .dec_bpc_vld_o(dec_bpc_vld_o), .dec_bpc_rdy_i(dec_bpc_rdy_i),
    .dec_znz_o(dec_znz_o), .dec_znz_vld_o(dec_znz_vld_o), .dec_znz_rdy_i(dec_znz_rdy_i),
    .dec_data_i(dec_data_i), .dec_vld_i(dec_vld_i), .dec_rdy_o(dec_rdy_o),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nw();
    for (int i = 0; i < N; i++) begin
      req_nw_vld_i[i] = (nwq[i].size() > 0);
      req_nw_i[i*NWW +: NWW] = (nwq[i].size() > 0) ? NWW'(nwq[i][0]) : '0;
    end
  endtask

  // Reference arbitration: first requester with a pending header, searching from the pointer.
  function automatic int model_pick();
    for (int k = 0; k < N; k++)
      if (nwq[(m_ptr + k) % N].size() > 0) return (m_ptr + k) % N;
    return 0;
  endfunction

  // Serves one block for the requester the model expects to win; rst_at >= 0 resets at that output word.
  task automatic blk(input int nbpc, input int nznz, input int bpmax, input int rst_at);
    int w, nw, cyc;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_q[$];
    logic is_b;
    w  = model_pick();
    nw = nwq[w][0];
    cyc = 0;
    while (!busy_o && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("grant_owner", 64'(grant_o), 64'(1) << w);
    repeat ($urandom_range(0, bpmax)) begin
      chk("hdr_hold_vld", 64'(dec_nw_vld_o), 64'(1));
      tick();
    end
    dec_nw_rdy_i = 1'b1;
    #1;
    chk("hdr_vld", 64'(dec_nw_vld_o), 64'(1));
    chk("hdr_nw", 64'(dec_nw_o), 64'(nw));
    chk("hdr_rdy_route", 64'(req_nw_rdy_o), 64'(1) << w);
    tick();
    dec_nw_rdy_i = 1'b0;
    void'(nwq[w].pop_front());
    drive_nw();
    #1;
    if (nw == 0) begin
      chk("zero_idle_busy", 64'(busy_o), 64'(0));
      chk("zero_idle_grant", 64'(grant_o), 64'(0));
      m_ptr = (w + 1) % N;
      return;
    end
    for (int k = 0; k < nbpc + nznz; k++) begin
      is_b = (k < nbpc);
      d = DW'($urandom);
      if (is_b) begin
        req_bpc_vld_i = '1;
        req_bpc_i = (N*DW)'($urandom);
        req_bpc_i[w*DW +: DW] = d;
      end else begin
        req_znz_vld_i = '1;
        req_znz_i = (N*DW)'($urandom);
        req_znz_i[w*DW +: DW] = d;
      end
      repeat ($urandom_range(0, bpmax)) begin
        #1;
        chk("stall_stream_rdy", 64'({req_bpc_rdy_o, req_znz_rdy_o}), 64'(0));
        tick();
      end
      if (is_b) dec_bpc_rdy_i = 1'b1; else dec_znz_rdy_i = 1'b1;
      #1;
      if (is_b) begin
        chk("bpc_fwd", 64'(dec_bpc_o), 64'(d));
        chk("bpc_rdy_route", 64'(req_bpc_rdy_o), 64'(1) << w);
      end else begin
        chk("znz_fwd", 64'(dec_znz_o), 64'(d));
        chk("znz_rdy_route", 64'(req_znz_rdy_o), 64'(1) << w);
      end
      chk("data_nw_vld", 64'(dec_nw_vld_o), 64'(0));
      chk("data_nw_rdy", 64'(req_nw_rdy_o), 64'(0));
      tick();
      req_bpc_vld_i = '0;
      req_znz_vld_i = '0;
      dec_bpc_rdy_i = 1'b0;
      dec_znz_rdy_i = 1'b0;
    end
    for (int k = 0; k < nw; k++) begin
      repeat ($urandom_range(0, bpmax)) begin
        dec_vld_i = 1'b0;
        req_data_rdy_i = '1;
        #1;
        chk("out_gap_vld", 64'(req_data_vld_o), 64'(0));
        tick();
      end
      d = DW'($urandom);
      dec_data_i = d;
      dec_vld_i = 1'b1;
      exp_q.push_back(d);
      if (k == rst_at) begin
        rst_i = 1'b1;
        #1;
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_rdys", 64'({req_nw_rdy_o, req_bpc_rdy_o, req_znz_rdy_o, dec_rdy_o}), 64'(0));
        chk("rst_vlds", 64'({req_data_vld_o, req_data_last_o, dec_nw_vld_o,
                             dec_bpc_vld_o, dec_znz_vld_o}), 64'(0));
        chk("rst_buses", 64'({req_data_o, dec_nw_o, dec_bpc_o, dec_znz_o}), 64'(0));
        tick();
        rst_i = 1'b0;
        dec_vld_i = 1'b0;
        req_data_rdy_i = '0;
        m_ptr = 0;
        return;
      end
      repeat ($urandom_range(0, bpmax)) begin
        req_data_rdy_i = ~(N'(1) << w);
        #1;
        chk("out_stall_rdy", 64'(dec_rdy_o), 64'(0));
        chk("out_vld_route", 64'(req_data_vld_o), 64'(1) << w);
        tick();
      end
      req_data_rdy_i = '1;
      #1;
      chk("out_data", 64'(req_data_o), 64'(exp_q.pop_front()));
      chk("out_last", 64'(req_data_last_o), 64'(k == nw - 1));
      tick();
    end
    dec_vld_i = 1'b0;
    req_data_rdy_i = '0;
    #1;
    chk("end_busy", 64'(busy_o), 64'(0));
    chk("end_grant", 64'(grant_o), 64'(0));
    m_ptr = (w + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    req_nw_i = '0;       req_nw_vld_i = '0;
    req_bpc_i = '0;      req_bpc_vld_i = '0;
    req_znz_i = '0;      req_znz_vld_i = '0;
    req_data_rdy_i = '0; dec_nw_rdy_i = 1'b0;
    dec_bpc_rdy_i = 1'b0; dec_znz_rdy_i = 1'b0;
    dec_data_i = '0;     dec_vld_i = 1'b0;
    tick();
    tick();
    chk("reset_busy", 64'(busy_o), 64'(0));
    chk("reset_grant", 64'(grant_o), 64'(0));
    chk("reset_outs", 64'({req_nw_rdy_o, req_bpc_rdy_o, req_znz_rdy_o, req_data_vld_o,
                           req_data_last_o, dec_nw_vld_o, dec_bpc_vld_o, dec_znz_vld_o,
                           dec_rdy_o}), 64'(0));
    chk("reset_buses", 64'({req_data_o, dec_nw_o, dec_bpc_o, dec_znz_o}), 64'(0));
    rst_i = 1'b0;
    tick();

    // Single requester, 4 words with 3 bpc and 2 znz.
    nwq[0].push_back(4);
    drive_nw();
    blk(3, 2, 0, -1);

    // Two competing requesters, two headers each.
    nwq[0].push_back(3); nwq[0].push_back(2);
    nwq[1].push_back(2); nwq[1].push_back(5);
    drive_nw();
    repeat (4) blk(2, 2, 1, -1);

    // Empty block.
    nwq[2].push_back(0);
    drive_nw();
    blk(0, 0, 0, -1);

    // Long block under random backpressure while another requester waits.
    nwq[0].push_back(16);
    nwq[1].push_back(3);
    drive_nw();
    blk(4, 4, 3, -1);
    blk(1, 1, 2, -1);

    // Second header presented during DATA must wait for the block to finish.
    nwq[2].push_back(6); nwq[2].push_back(2);
    drive_nw();
    blk(2, 2, 1, -1);
    blk(1, 1, 1, -1);

    // Reset at the third output word, then a clean block.
    nwq[1].push_back(10);
    drive_nw();
    blk(2, 2, 1, 2);
    tick();
    nwq[0].push_back(5);
    drive_nw();
    blk(2, 1, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ebpc_decoder_arbiter.md
Name: ebpc_decoder_arbiter

Overview:
- Shares one ebpc_decoder instance between N_REQ requesters, each presenting its own num_words, bpc and znz handshake streams.
- Grants the decoder to one requester for a whole block, from num_words acceptance to the final output word, using round-robin order.
- Routes decoded output back to the granted requester and marks the final word with last.
- Sits between the requester stream sources and the ebpc_decoder.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 8, bpc/znz/data word width.
- NW_W, LOG_MAX_WORDS, width of the num_words field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_nw_i  in  N_REQ*NW_W  per-requester num_words.
- req_nw_vld_i / req_nw_rdy_o  in/out  N_REQ  num_words handshake.
- req_bpc_i  in  N_REQ*DATA_W  per-requester bpc stream; req_bpc_vld_i / req_bpc_rdy_o  in/out  N_REQ.
- req_znz_i  in  N_REQ*DATA_W  per-requester znz stream; req_znz_vld_i / req_znz_rdy_o  in/out  N_REQ.
- req_data_o  out  DATA_W  decoded word, shared bus.
- req_data_vld_o / req_data_rdy_i  out/in  N_REQ  per-requester output handshake.
- req_data_last_o  out  1  final word of the block.
- dec_nw_o, dec_nw_vld_o, dec_nw_rdy_i  out/out/in  NW_W/1/1  to decoder.
- dec_bpc_o, dec_bpc_vld_o, dec_bpc_rdy_i  out/out/in  DATA_W/1/1  to decoder.
- dec_znz_o, dec_znz_vld_o, dec_znz_rdy_i  out/out/in  DATA_W/1/1  to decoder.
- dec_data_i, dec_vld_i, dec_rdy_o  in/in/out  DATA_W/1/1  from decoder.
- grant_o  out  N_REQ  one-hot current owner; 0 when idle.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - FSM=IDLE, rr_ptr=0, grant=0, counters=0.
  - All vld/rdy outputs 0; data buses 0; last 0.
- FSM states IDLE -> HDR -> DATA -> IDLE.
- IDLE:
  - Scan req_nw_vld_i starting at rr_ptr, wrapping; the first set index wins.
  - Register grant and go to HDR next cycle (1-cycle arbitration latency).
  - No rdy is asserted in IDLE.
- HDR:
  - dec_nw_* forwarded combinationally from the granted requester; req_nw_rdy_o[g]=dec_nw_rdy_i.
  - On handshake, latch remaining = num_words.
  - num_words != 0 -> DATA; num_words == 0 -> IDLE with rr_ptr=g+1.
- HDR and DATA, bpc/znz path:
  - bpc and znz are forwarded combinationally from requester g, including rdy back to g.
  - All non-granted rdy stay 0.
- DATA, num_words path: dec_nw_vld_o=0, so a second header is never forwarded inside a grant.
- DATA, output path:
  - req_data_o=dec_data_i; req_data_vld_o[g]=dec_vld_i; dec_rdy_o=req_data_rdy_i[g].
  - req_data_last_o = (remaining==1) & dec_vld_i.
  - Each output handshake decrements remaining.
  - Handshake with remaining==1 -> IDLE, grant=0, rr_ptr=(g+1) mod N_REQ.
- No combinational path from any requester vld to any requester rdy except through the granted mux.
- Decoder contract: the decoder has consumed all bpc/znz words of the block before emitting its last output word. The arbiter does not check this.
- Simultaneous events:
  - A requester raising nw_vld during another's DATA waits; fairness is guaranteed by rr_ptr.
  - A non-granted requester dropping vld causes no state change.
- Reset mid-operation: immediate return to IDLE. In-flight decoder state is not flushed; the decoder shares the reset net, tied by the integrator.
- remaining is NW_W bits; no wrap, because a decrement happens only while nonzero.

Decomposition:
- ebpc_pkg additions:
  - arb_state_t enum {IDLE, HDR, DATA}.
  - MAX_REQ=8.
  - Reuse LOG_MAX_WORDS.
- Sub-module rr_arbiter (N_REQ): combinational round-robin pick from a request vector and rr_ptr. Outputs are a one-hot grant and a valid flag.
- The FSM, muxes and counter live in the top.

Test Plan:
- Single requester 0, num_words=4, 3 bpc and 2 znz words; decoder model emits 4 words -> req0 receives 4 words, last on the 4th only. grant_o goes 01 -> 00; rr_ptr=1.
- Requesters 0 and 1 both raise nw_vld at reset release -> order 0,1,0,1 over 4 blocks. Non-granted rdy stays 0 throughout.
- num_words=0 from requester 1 -> one header handshake, no output, IDLE after 1 cycle, rr_ptr=0 (N_REQ=2).
- Random backpressure 0-3 cycles on req_data_rdy_i and decoder rdy, num_words=16 -> exactly 16 words, last on the 16th. No drops or duplicates versus the expresp file.
- Requester 2 of 3 sends a second header during DATA -> not forwarded until the block completes; dec_nw_vld_o stays 0 in DATA.
- Assert rst_i at the 3rd output word of a 10-word block -> same cycle: all vld/rdy 0, busy_o=0, grant_o=0. After release, a new block from requester 0 decodes correctly.
